// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word, fetch FSM state and opcode definitions
`timescale 1ns/1ps
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_HALT = 6'h3F;

  // Fetch addresses are always word aligned.
  function automatic word_t pc_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, one-entry skid buffer and IF/ID register
`timescale 1ns/1ps
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] npc,
  output logic        halted
);

  fetch_state_t state, state_n;
  word_t pc, pc_n, pc_inc;
  word_t instr_n, npc_n, skid, skid_n, skid_npc, skid_npc_n;
  logic  valid_n, halted_n;

  assign pc_inc   = pc + 32'd4;
  assign imemaddr = pc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      instr       <= '0;
      npc         <= '0;
      skid        <= '0;
      skid_npc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      npc         <= npc_n;
      skid        <= skid_n;
      skid_npc    <= skid_npc_n;
      instr_valid <= valid_n;
      halted      <= halted_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    npc_n      = npc;
    skid_n     = skid;
    skid_npc_n = skid_npc;
    valid_n    = instr_valid;
    halted_n   = halted;
    imemREN    = (state == FETCH);

    // Priority: halt > redirect > normal fetch/hold flow; HALT ignores everything.
    if (state != HALT) begin
      if (halt && instr_valid) begin
        state_n  = HALT;
        valid_n  = 1'b0;
        halted_n = 1'b1;
      end else if (redirect) begin
        state_n    = FETCH;
        pc_n       = pc_align(redirect_pc);
        valid_n    = 1'b0;
        skid_n     = '0;
        skid_npc_n = '0;
      end else if (state == FETCH) begin
        if (ihit && !stall) begin
          instr_n = imemload;
          npc_n   = pc_inc;
          valid_n = 1'b1;
          pc_n    = pc_inc;
        end else if (ihit && stall) begin
          skid_n     = imemload;
          skid_npc_n = pc_inc;
          pc_n       = pc_inc;
          state_n    = HOLD;
        end else if (!stall) begin
          valid_n = 1'b0;
        end
      end else if (!stall) begin
        instr_n = skid;
        npc_n   = skid_npc;
        valid_n = 1'b1;
        state_n = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] npc;
  logic        halted;

  logic        override;
  logic [31:0] ovr_word;
  int          total;
  int          bad;

  // Memory image: word at address a is {a[15:0], 16'hA5A5}.
  assign imemload = override ? ovr_word : {imemaddr[15:0], 16'hA5A5};

  fetch_stage #(.PC_INIT(32'h00000000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr(instr),
    .instr_valid(instr_valid), .npc(npc), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic h, input logic s, input logic r, input logic [31:0] rpc, input logic hl);
    ihit = h; stall = s; redirect = r; redirect_pc = rpc; halt = hl;
  endtask

  task automatic test_reset();
    nRST = 1'b0; override = 1'b0; ovr_word = '0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(); step();
    total++; if (imemaddr !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", imemaddr, 32'h0); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== 32'h0 || npc !== 32'h0) begin bad++; $display("FAIL reset_ifid got=%h/%h exp=0/0", instr, npc); end
    total++; if (halted !== 1'b0 || imemREN !== 1'b1) begin bad++; $display("FAIL reset_ctl got=%b/%b exp=0/1", halted, imemREN); end
    nRST = 1'b1;
  endtask

  task automatic test_sequential();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (imemaddr !== 32'h4) begin bad++; $display("FAIL seq_pc1 got=%h exp=%h", imemaddr, 32'h4); end
    total++; if (instr !== 32'h0000A5A5 || npc !== 32'h4 || instr_valid !== 1'b1) begin bad++; $display("FAIL seq_ifid1 got=%h/%h/%b exp=0000a5a5/4/1", instr, npc, instr_valid); end
    step();
    total++; if (imemaddr !== 32'h8) begin bad++; $display("FAIL seq_pc2 got=%h exp=%h", imemaddr, 32'h8); end
    total++; if (instr !== 32'h0004A5A5 || npc !== 32'h8) begin bad++; $display("FAIL seq_ifid2 got=%h/%h exp=0004a5a5/8", instr, npc); end
  endtask

  task automatic test_stall_hold();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (imemREN !== 1'b0 || imemaddr !== 32'hC) begin bad++; $display("FAIL hold_enter got=%b/%h exp=0/0000000c", imemREN, imemaddr); end
    total++; if (instr !== 32'h0004A5A5 || instr_valid !== 1'b1) begin bad++; $display("FAIL hold_keep got=%h/%b exp=0004a5a5/1", instr, instr_valid); end
    step();
    total++; if (imemREN !== 1'b0 || imemaddr !== 32'hC || instr !== 32'h0004A5A5) begin bad++; $display("FAIL hold_stay got=%b/%h/%h exp=0/c/0004a5a5", imemREN, imemaddr, instr); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (instr !== 32'h0008A5A5 || npc !== 32'hC || instr_valid !== 1'b1) begin bad++; $display("FAIL hold_release got=%h/%h/%b exp=0008a5a5/c/1", instr, npc, instr_valid); end
    total++; if (imemREN !== 1'b1 || imemaddr !== 32'hC) begin bad++; $display("FAIL hold_back got=%b/%h exp=1/c", imemREN, imemaddr); end
  endtask

  task automatic test_bubble();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (instr !== 32'h000CA5A5 || imemaddr !== 32'h10) begin bad++; $display("FAIL bub_fetch got=%h/%h exp=000ca5a5/10", instr, imemaddr); end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (instr_valid !== 1'b1 || imemaddr !== 32'h10 || instr !== 32'h000CA5A5) begin bad++; $display("FAIL bub_hold got=%b/%h/%h exp=1/10/000ca5a5", instr_valid, imemaddr, instr); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (instr_valid !== 1'b0 || imemaddr !== 32'h10) begin bad++; $display("FAIL bub_insert got=%b/%h exp=0/10", instr_valid, imemaddr); end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 1'b1, 32'h00000043, 1'b0);
    step();
    total++; if (imemaddr !== 32'h40 || instr_valid !== 1'b0) begin bad++; $display("FAIL redir_fetch got=%h/%b exp=40/0", imemaddr, instr_valid); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (instr !== 32'h0040A5A5 || npc !== 32'h44 || instr_valid !== 1'b1) begin bad++; $display("FAIL redir_target got=%h/%h/%b exp=0040a5a5/44/1", instr, npc, instr_valid); end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (imemREN !== 1'b0 || imemaddr !== 32'h48) begin bad++; $display("FAIL redir_hold_in got=%b/%h exp=0/48", imemREN, imemaddr); end
    drive(1'b1, 1'b1, 1'b1, 32'h00000100, 1'b0);
    step();
    total++; if (imemREN !== 1'b1 || imemaddr !== 32'h100 || instr_valid !== 1'b0) begin bad++; $display("FAIL redir_hold got=%b/%h/%b exp=1/100/0", imemREN, imemaddr, instr_valid); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (instr_valid !== 1'b0 || imemaddr !== 32'h100) begin bad++; $display("FAIL redir_skid_drop got=%b/%h exp=0/100", instr_valid, imemaddr); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
    step();
    total++; if (imemaddr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_setup got=%h exp=fffffffc", imemaddr); end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (imemaddr !== 32'h0 || npc !== 32'h0 || instr !== 32'hFFFCA5A5) begin bad++; $display("FAIL wrap got=%h/%h/%h exp=0/0/fffca5a5", imemaddr, npc, instr); end
  endtask

  task automatic test_reset_in_hold();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (imemREN !== 1'b0 || imemaddr !== 32'h4) begin bad++; $display("FAIL rsthold_in got=%b/%h exp=0/4", imemREN, imemaddr); end
    nRST = 1'b0;
    #1;
    total++; if (imemREN !== 1'b1 || imemaddr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rsthold_async got=%b/%h/%b exp=1/0/0", imemREN, imemaddr, instr_valid); end
    step();
    nRST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (instr_valid !== 1'b0 || imemaddr !== 32'h0 || imemREN !== 1'b1) begin bad++; $display("FAIL rsthold_restart got=%b/%h/%b exp=0/0/1", instr_valid, imemaddr, imemREN); end
  endtask

  task automatic test_halt();
    override = 1'b1; ovr_word = 32'hFC000000;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    total++; if (instr !== 32'hFC000000 || instr_valid !== 1'b1 || imemaddr !== 32'h4) begin bad++; $display("FAIL halt_load got=%h/%b/%h exp=fc000000/1/4", instr, instr_valid, imemaddr); end
    drive(1'b1, 1'b0, 1'b1, 32'h00000080, 1'b1);
    step();
    total++; if (halted !== 1'b1 || imemREN !== 1'b0 || instr_valid !== 1'b0 || imemaddr !== 32'h4) begin bad++; $display("FAIL halt_enter got=%b/%b/%b/%h exp=1/0/0/4", halted, imemREN, instr_valid, imemaddr); end
    for (int i = 0; i < 12; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
      step();
      total++; if (halted !== 1'b1 || imemREN !== 1'b0 || imemaddr !== 32'h4 || instr_valid !== 1'b0) begin bad++; $display("FAIL halt_absorb[%0d] got=%b/%b/%h/%b exp=1/0/4/0", i, halted, imemREN, imemaddr, instr_valid); end
    end
    override = 1'b0;
    nRST = 1'b0;
    #1;
    total++; if (halted !== 1'b0 || imemaddr !== 32'h0 || imemREN !== 1'b1) begin bad++; $display("FAIL halt_reset got=%b/%h/%b exp=0/0/1", halted, imemaddr, imemREN); end
    step();
    nRST = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_bubble();
    test_redirect();
    test_wrap();
    test_reset_in_hold();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: PC_INIT, default 32'h00000000, PC value loaded at reset.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 ihit  input  1  instruction memory returned imemload this cycle.
REQ-005 imemload  input  32  instruction word from memory.
REQ-006 stall  input  1  decode/downstream cannot accept a new IF/ID word.
REQ-007 redirect  input  1  taken branch/jump; fetch shall restart at redirect_pc.
REQ-008 redirect_pc  input  32  redirect target address.
REQ-009 halt  input  1  decoder has seen HALT (opcode 6'h3F) in the IF/ID word.
REQ-010 imemREN  output  1  instruction read request.
REQ-011 imemaddr  output  32  fetch address, equal to the PC register.
REQ-012 instr  output  32  IF/ID instruction register, feeds the control unit.
REQ-013 instr_valid  output  1  instr holds a real instruction; 0 means bubble.
REQ-014 npc  output  32  PC+4 of the instruction in instr.
REQ-015 halted  output  1  sticky halt indicator.

Function
REQ-016 The block SHALL implement FSM states FETCH, HOLD, HALT.
REQ-017 In FETCH: imemREN=1; in HOLD and HALT: imemREN=0.
REQ-018 FETCH, ihit=1, stall=0: instr<=imemload, npc<=pc+4, instr_valid<=1, pc<=pc+4.
REQ-019 FETCH, ihit=1, stall=1: skid<=imemload, skid_npc<=pc+4, pc<=pc+4, go HOLD; instr/instr_valid unchanged.
REQ-020 FETCH, ihit=0, stall=0: instr_valid<=0 (bubble); pc unchanged.
REQ-021 FETCH, ihit=0, stall=1: all registers hold.
REQ-022 HOLD, stall=0: instr<=skid, npc<=skid_npc, instr_valid<=1, go FETCH; HOLD, stall=1: hold.
REQ-023 Fetch-to-instr latency SHALL be one cycle after ihit when unstalled.
REQ-024 redirect=1 in FETCH or HOLD: pc<={redirect_pc[31:2],2'b00}, instr_valid<=0, skid discarded, go FETCH; overrides ihit and stall same cycle (fetched word dropped).
REQ-025 halt=1 with instr_valid=1: go HALT, instr_valid<=0, halted<=1; halt has priority over redirect, ihit, stall.
REQ-026 HALT SHALL be absorbing until reset; pc frozen, all inputs ignored.
REQ-027 pc arithmetic SHALL be modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
REQ-028 instr value SHALL be ignored by consumers whenever instr_valid=0.

Reset
REQ-029 nRST=0 SHALL asynchronously force: pc=PC_INIT, state=FETCH, instr=0, npc=0, skid=0, instr_valid=0, halted=0.
REQ-030 Reset mid-HOLD or mid-HALT SHALL discard skid and restart in FETCH at PC_INIT on the first edge after deassertion.

Structure
REQ-031 word_t, the fetch_state_t enum (FETCH, HOLD, HALT) and the HALT opcode constant SHALL live in cpu_types_pkg.
REQ-032 No sub-module; PC, skid and IF/ID registers are in one module.

Verification
REQ-033 Reset, ihit=1 every cycle, PC_INIT=0 -> imemaddr 0,4,8; instr follows one cycle later; npc=4,8,12.
REQ-034 ihit=1, stall=1 at pc=8 -> HOLD, imemREN=0, pc=12; stall released -> instr=word@8, npc=12, back to FETCH.
REQ-035 redirect=1, redirect_pc=32'h00000043, ihit=1 same cycle -> pc=32'h00000040, instr_valid=0, fetched word dropped.
REQ-036 instr=32'hFC000000 valid, halt=1, redirect=1 -> halted=1, imemREN=0, pc frozen for 10+ cycles.
REQ-037 pc=32'hFFFFFFFC, ihit=1 -> next imemaddr=0, npc=0; nRST pulsed in HOLD -> state FETCH, pc=PC_INIT, instr_valid=0.
